// File: rtl/gps_ca_acq.sv
// GPS C/A-code serial acquisition engine.
// Slides a local Gold-code replica across the stream until one dwell agrees.
`timescale 1ns/1ps
module gps_ca_acq #(
  parameter int WINDOW = 64,
  parameter int THRESH = 60,
  localparam int CW = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [5:0]    prn_num,
  input  logic          chip_in,
  input  logic          chip_valid,
  output logic          busy,
  output logic          locked,
  output logic          lock_fail,
  output logic [9:0]    code_phase,
  output logic [CW-1:0] corr_peak
);

  typedef enum logic [2:0] {
    IDLE, DWELL, SLIP, LOCK, FAIL
  } state_t;

  state_t        state, state_n;
  logic [9:0]    g1, g1_n;
  logic [9:0]    g2, g2_n;
  logic [9:0]    slip, slip_n;
  logic [9:0]    phase_n;
  logic [5:0]    prn, prn_n;
  logic [CW-1:0] agree, agree_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic [CW-1:0] maxc, maxc_n;
  logic [CW-1:0] peak_n;
  logic [CW-1:0] agree_inc;
  logic [CW-1:0] best;
  logic [3:0]    tap_a, tap_b;
  logic          replica;

  // G2 phase-select taps, stored zero-based (stage k is bit k-1)
  always_comb begin
    tap_a = 4'd0;
    tap_b = 4'd0;
    case (prn)
      6'd1:  begin tap_a = 4'd1; tap_b = 4'd5; end
      6'd2:  begin tap_a = 4'd2; tap_b = 4'd6; end
      6'd3:  begin tap_a = 4'd3; tap_b = 4'd7; end
      6'd4:  begin tap_a = 4'd4; tap_b = 4'd8; end
      6'd5:  begin tap_a = 4'd0; tap_b = 4'd8; end
      6'd6:  begin tap_a = 4'd1; tap_b = 4'd9; end
      6'd7:  begin tap_a = 4'd0; tap_b = 4'd7; end
      6'd8:  begin tap_a = 4'd1; tap_b = 4'd8; end
      6'd9:  begin tap_a = 4'd2; tap_b = 4'd9; end
      6'd10: begin tap_a = 4'd1; tap_b = 4'd2; end
      6'd11: begin tap_a = 4'd2; tap_b = 4'd3; end
      6'd12: begin tap_a = 4'd4; tap_b = 4'd5; end
      6'd13: begin tap_a = 4'd5; tap_b = 4'd6; end
      6'd14: begin tap_a = 4'd6; tap_b = 4'd7; end
      6'd15: begin tap_a = 4'd7; tap_b = 4'd8; end
      6'd16: begin tap_a = 4'd8; tap_b = 4'd9; end
      6'd17: begin tap_a = 4'd0; tap_b = 4'd3; end
      6'd18: begin tap_a = 4'd1; tap_b = 4'd4; end
      6'd19: begin tap_a = 4'd2; tap_b = 4'd5; end
      6'd20: begin tap_a = 4'd3; tap_b = 4'd6; end
      6'd21: begin tap_a = 4'd4; tap_b = 4'd7; end
      6'd22: begin tap_a = 4'd5; tap_b = 4'd8; end
      6'd23: begin tap_a = 4'd0; tap_b = 4'd2; end
      6'd24: begin tap_a = 4'd3; tap_b = 4'd5; end
      6'd25: begin tap_a = 4'd4; tap_b = 4'd6; end
      6'd26: begin tap_a = 4'd5; tap_b = 4'd7; end
      6'd27: begin tap_a = 4'd6; tap_b = 4'd8; end
      6'd28: begin tap_a = 4'd7; tap_b = 4'd9; end
      6'd29: begin tap_a = 4'd0; tap_b = 4'd5; end
      6'd30: begin tap_a = 4'd1; tap_b = 4'd6; end
      6'd31: begin tap_a = 4'd2; tap_b = 4'd7; end
      6'd32: begin tap_a = 4'd3; tap_b = 4'd8; end
      default: begin tap_a = 4'd0; tap_b = 4'd0; end
    endcase
  end

  // replica chip and the agreement count including the current chip
  always_comb begin
    replica   = g1[9] ^ g2[tap_a] ^ g2[tap_b];
    agree_inc = agree + CW'(chip_in == replica);
    best      = (agree_inc > maxc) ? agree_inc : maxc;
  end

  // next-state and datapath; start overrides everything else
  always_comb begin
    state_n = state;
    g1_n    = g1;
    g2_n    = g2;
    slip_n  = slip;
    prn_n   = prn;
    agree_n = agree;
    wcnt_n  = wcnt;
    maxc_n  = maxc;
    peak_n  = corr_peak;
    phase_n = code_phase;
    if (start) begin
      prn_n   = prn_num;
      g1_n    = '1;
      g2_n    = '1;
      slip_n  = '0;
      agree_n = '0;
      wcnt_n  = '0;
      maxc_n  = '0;
      peak_n  = '0;
      phase_n = '0;
      if (prn_num == 6'd0 || prn_num > 6'd32)
        state_n = FAIL;
      else
        state_n = DWELL;
    end else begin
      case (state)
        DWELL: begin
          if (chip_valid) begin
            g1_n    = {g1[8:0], g1[2] ^ g1[9]};
            g2_n    = {g2[8:0], g2[1] ^ g2[2] ^ g2[5]
                               ^ g2[7] ^ g2[8] ^ g2[9]};
            agree_n = agree_inc;
            wcnt_n  = wcnt + CW'(1);
            if (wcnt == CW'(WINDOW - 1)) begin
              if (agree_inc >= CW'(THRESH)) begin
                state_n = LOCK;
                peak_n  = agree_inc;
                phase_n = (slip == 10'd0) ? 10'd0
                                          : 10'd1023 - slip;
              end else begin
                maxc_n = best;
                if (slip == 10'd1022) begin
                  state_n = FAIL;
                  peak_n  = best;
                end else begin
                  state_n = SLIP;
                end
              end
            end
          end
        end
        SLIP: begin
          if (chip_valid) begin
            slip_n  = slip + 10'd1;
            agree_n = '0;
            wcnt_n  = '0;
            state_n = DWELL;
          end
        end
        default: ;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      g1         <= '1;
      g2         <= '1;
      slip       <= '0;
      prn        <= '0;
      agree      <= '0;
      wcnt       <= '0;
      maxc       <= '0;
      corr_peak  <= '0;
      code_phase <= '0;
    end else begin
      state      <= state_n;
      g1         <= g1_n;
      g2         <= g2_n;
      slip       <= slip_n;
      prn        <= prn_n;
      agree      <= agree_n;
      wcnt       <= wcnt_n;
      maxc       <= maxc_n;
      corr_peak  <= peak_n;
      code_phase <= phase_n;
    end
  end

  // status flags decode straight from the state register
  always_comb begin
    busy      = (state == DWELL) || (state == SLIP);
    locked    = (state == LOCK);
    lock_fail = (state == FAIL);
  end

endmodule

// File: tb/tb_gps_ca_acq.sv
// Randomised bench for gps_ca_acq.
// Expected results come from a dwell-by-dwell search over generated code tables.
`timescale 1ns/1ps
module tb_gps_ca_acq;
  localparam int W  = 64;
  localparam int TH = 60;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    prn_num = '0;
  logic          chip_in = 1'b0;
  logic          chip_valid = 1'b0;
  logic          busy, locked, lock_fail;
  logic [9:0]    code_phase;
  logic [CW-1:0] corr_peak;

  int errors = 0;
  int checks = 0;

  bit code [0:32][0:1022];
  int ta [0:32] = '{0,2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,
                    1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int tb [0:32] = '{0,6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,
                    4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  gps_ca_acq #(.WINDOW(W), .THRESH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prn_num(prn_num),
    .chip_in(chip_in), .chip_valid(chip_valid), .busy(busy),
    .locked(locked), .lock_fail(lock_fail),
    .code_phase(code_phase), .corr_peak(corr_peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // C/A codes straight from the generator polynomials, stages 1..10
  task automatic gen_codes();
    bit g1 [1:10];
    bit g2 [1:10];
    bit f1, f2;
    for (int p = 1; p <= 32; p++) begin
      for (int k = 1; k <= 10; k++) begin
        g1[k] = 1'b1;
        g2[k] = 1'b1;
      end
      for (int i = 0; i < 1023; i++) begin
        code[p][i] = g1[10] ^ g2[ta[p]] ^ g2[tb[p]];
        f1 = g1[3] ^ g1[10];
        f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
        for (int k = 10; k >= 2; k--) begin
          g1[k] = g1[k-1];
          g2[k] = g2[k-1];
        end
        g1[1] = f1;
        g2[1] = f2;
      end
    end
  endtask

  // dwell s sees stream chips s*(W+1)+k against replica chips s*W+k
  task automatic ref_search(input int rp, input int sp, input int d,
                            output int lk, output int n,
                            output int pk, output int ph);
    int mx, ag;
    mx = 0;
    lk = 0;
    n  = 1023 * (W + 1) - 1;
    ph = 0;
    pk = 0;
    for (int s = 0; s < 1023; s++) begin
      ag = 0;
      for (int k = 0; k < W; k++)
        if (code[sp][(s * (W + 1) + k + d) % 1023]
            == code[rp][(s * W + k) % 1023])
          ag++;
      if (ag >= TH) begin
        lk = 1;
        n  = s * (W + 1) + W;
        pk = ag;
        ph = (1023 - s) % 1023;
        return;
      end
      if (ag > mx) mx = ag;
    end
    pk = mx;
  endtask

  task automatic run(input int rp, input int sp, input int d,
                     input int mode, input string tag);
    int lk, en, epk, eph, n, cyc, limit;
    bit v, done;
    ref_search(rp, sp, d, lk, en, epk, eph);
    @(negedge clk);
    start      = 1'b1;
    prn_num    = rp[5:0];
    chip_valid = 1'($urandom % 2);
    chip_in    = 1'($urandom % 2);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_up"}, busy, 1);
    n = 0;
    cyc = 0;
    done = 0;
    limit = 4 * en + 100;
    while (!done && cyc < limit) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (cyc % 2 == 0);
      else v = ($urandom % 3 != 0);
      chip_valid = v;
      chip_in = v ? code[sp][(n + d) % 1023] : 1'($urandom % 2);
      @(posedge clk);
      #1;
      if (v) n++;
      cyc++;
      if (locked || lock_fail) done = 1'b1;
      @(negedge clk);
    end
    chip_valid = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_locked"}, locked, lk);
    chk({tag, "_fail"}, lock_fail, lk == 0);
    chk({tag, "_chips"}, n, en);
    chk({tag, "_peak"}, corr_peak, epk);
    chk({tag, "_phase"}, code_phase, eph);
    chk({tag, "_busy_dn"}, busy, 0);
  endtask

  initial begin
    int v1, v2, s, lk0, n0, pk0, ph0;
    logic [31:0] snap;
    gen_codes();
    v1 = 0;
    v2 = 0;
    for (int i = 0; i < 10; i++) begin
      v1 = (v1 << 1) | code[1][i];
      v2 = (v2 << 1) | code[2][i];
    end
    chk("rep_prn1", v1, 'o1440);
    chk("rep_prn2", v2, 'o1620);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {busy, locked, lock_fail, code_phase, corr_peak}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(1, 1, 0, 0, "d0");
    snap = {locked, code_phase, corr_peak};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chip_valid = 1'($urandom % 2);
      chip_in = 1'($urandom % 2);
    end
    @(negedge clk);
    chk("hold", {locked, code_phase, corr_peak}, snap);

    run(1, 1, 1020, 1, "d1020");

    @(negedge clk);
    start = 1'b1;
    prn_num = 6'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("prn0_fail", lock_fail, 1);
    chk("prn0_busy", busy, 0);
    chk("prn0_peak", corr_peak, 0);
    @(negedge clk);
    start = 1'b1;
    prn_num = 6'd33;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("prn33_fail", lock_fail, 1);
    chk("prn33_busy", busy, 0);

    @(negedge clk);
    start = 1'b1;
    prn_num = 6'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      chip_valid = 1'b1;
      chip_in = code[5][(i + 10) % 1023];
      @(negedge clk);
    end
    chk("mid_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {busy, locked, lock_fail, code_phase, corr_peak}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    start = 1'b1;
    prn_num = 6'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chip_valid = 1'b1;
      chip_in = 1'($urandom % 2);
      @(negedge clk);
    end
    run(5, 5, 1021, 2, "restart");

    for (int t = 0; t < 6; t++) begin
      s = $urandom % 4;
      run(1 + ($urandom % 32), 1 + ($urandom % 32),
          (1023 - s) % 1023, 2, $sformatf("rnd%0d", t));
    end

    ref_search(1, 2, 0, lk0, n0, pk0, ph0);
    chk("xprn_peak_lt", pk0 < TH, 1);
    run(1, 2, 0, 0, "xprn");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
